// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input loader.
//   DATA_W / MAX_N        : default sample width and number of parallel lanes
//   LOG2_MAX_N / LOG2_W   : lane-index width and width of a log2(N) value
//   FFT_SEL_*             : encodings of the transform-size select input
//   state_t               : loader FSM states
//   sel_to_log2n()        : maps a size select to log2 of the transform size
package fft_pkg;

  localparam int DATA_W     = 16;
  localparam int MAX_N      = 32;
  localparam int LOG2_MAX_N = $clog2(MAX_N);
  localparam int LOG2_W     = $clog2(LOG2_MAX_N + 1);

  localparam logic [1:0] FFT_SEL_8    = 2'd0;
  localparam logic [1:0] FFT_SEL_16   = 2'd1;
  localparam logic [1:0] FFT_SEL_32   = 2'd2;
  localparam logic [1:0] FFT_SEL_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIRE = 2'd2,
    WAIT = 2'd3
  } state_t;

  // The reserved encoding falls back to the smallest size; the FSM never
  // latches it because nothing is accepted while it is selected.
  function automatic logic [LOG2_W-1:0] sel_to_log2n(input logic [1:0] sel);
    case (sel)
      FFT_SEL_16: sel_to_log2n = LOG2_W'(4);
      FFT_SEL_32: sel_to_log2n = LOG2_W'(5);
      default:    sel_to_log2n = LOG2_W'(3);
    endcase
  endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Combinational bit-reversed lane address.
//   cnt      : sample number within the frame
//   log2n    : log2 of the transform size (number of bits to reverse)
//   lane_idx : cnt with its low log2n bits reversed; always below N
module fft_bitrev_addr
  import fft_pkg::*;
#(
  parameter int CNT_W = LOG2_MAX_N,
  parameter int L2_W  = LOG2_W
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [L2_W-1:0]  log2n,
  output logic [CNT_W-1:0] lane_idx
);

  logic [CNT_W-1:0] rev_full;

  // Reverse across the full counter width, then shift right so only the
  // reversed low log2n bits remain.
  always_comb begin
    rev_full = '0;
    for (int i = 0; i < CNT_W; i++) begin
      rev_full[i] = cnt[CNT_W-1-i];
    end
    lane_idx = rev_full >> (L2_W'(CNT_W) - log2n);
  end

endmodule

// File: rtl/fft_input_loader.sv
// Serial-to-parallel loader feeding an 8/16/32-point FFT engine.
// Samples arrive one per accepted cycle and are written to lanes in
// bit-reversed order; once N samples are in, a one-cycle start strobe goes
// to the engine of the latched size, and the lanes are held until the
// engine reports done.
//   clk_i, rst_i                : clock, synchronous active-high reset
//   fft_select_i                : size select (0=8, 1=16, 2=32, 3=reserved)
//   sample_valid_i/sample_ready_o : serial sample handshake
//   sample_R_i, sample_I_i      : serial sample real / imaginary parts
//   X_R_o, X_I_o                : parallel lanes, lane k at [k*DATA_W +: DATA_W]
//   start_fft8/16/32_o          : one-cycle engine start strobes
//   fft_done_i                  : started engine finished with the lanes
//   busy_o                      : loader is not idle
module fft_input_loader #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int MAX_N  = fft_pkg::MAX_N
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              fft_select_i,
  input  logic                    sample_valid_i,
  output logic                    sample_ready_o,
  input  logic [DATA_W-1:0]       sample_R_i,
  input  logic [DATA_W-1:0]       sample_I_i,
  output logic [MAX_N*DATA_W-1:0] X_R_o,
  output logic [MAX_N*DATA_W-1:0] X_I_o,
  output logic                    start_fft8_o,
  output logic                    start_fft16_o,
  output logic                    start_fft32_o,
  input  logic                    fft_done_i,
  output logic                    busy_o
);

  import fft_pkg::*;

  localparam int CNT_W = $clog2(MAX_N);
  localparam int L2_W  = LOG2_W;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [L2_W-1:0]    log2n_q;
  logic [DATA_W-1:0]  lane_r_q [MAX_N];
  logic [DATA_W-1:0]  lane_i_q [MAX_N];

  logic               accept;
  logic               last;
  logic [CNT_W-1:0]   cnt_eff;
  logic [CNT_W-1:0]   n_minus1;
  logic [L2_W-1:0]    log2n_eff;
  logic [CNT_W-1:0]   lane_idx;

  fft_bitrev_addr #(
    .CNT_W (CNT_W),
    .L2_W  (L2_W)
  ) u_bitrev (
    .cnt      (cnt_eff),
    .log2n    (log2n_eff),
    .lane_idx (lane_idx)
  );

  // In IDLE the frame has not started yet: the size comes straight from the
  // select input and the sample number is 0, so the first acceptance can be
  // handled in the same cycle it happens.
  always_comb begin
    state_d        = state_q;
    sample_ready_o = 1'b0;
    start_fft8_o   = 1'b0;
    start_fft16_o  = 1'b0;
    start_fft32_o  = 1'b0;
    busy_o         = (state_q != IDLE);
    log2n_eff      = (state_q == IDLE) ? sel_to_log2n(fft_select_i) : log2n_q;
    cnt_eff        = (state_q == IDLE) ? '0 : cnt_q;
    n_minus1       = CNT_W'((1 << log2n_eff) - 1);
    last           = (cnt_eff == n_minus1);

    case (state_q)
      IDLE:    sample_ready_o = (fft_select_i != FFT_SEL_RSVD);
      LOAD:    sample_ready_o = 1'b1;
      default: sample_ready_o = 1'b0;
    endcase

    accept = sample_valid_i && sample_ready_o;

    case (state_q)
      IDLE: begin
        if (accept) state_d = last ? FIRE : LOAD;
      end
      LOAD: begin
        if (accept && last) state_d = FIRE;
      end
      FIRE: begin
        state_d = WAIT;
        // A reset arriving during FIRE suppresses the strobe in that cycle.
        if (!rst_i) begin
          start_fft8_o  = (log2n_q == sel_to_log2n(FFT_SEL_8));
          start_fft16_o = (log2n_q == sel_to_log2n(FFT_SEL_16));
          start_fft32_o = (log2n_q == sel_to_log2n(FFT_SEL_32));
        end
      end
      WAIT: begin
        if (fft_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      log2n_q <= sel_to_log2n(FFT_SEL_8);
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= last ? '0 : cnt_eff + 1'b1;
        if (state_q == IDLE) log2n_q <= log2n_eff;
      end
    end
  end

  // The first acceptance of a frame clears every lane so that lanes at or
  // above the new N read zero; the later write to lane 0 wins over the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < MAX_N; k++) begin
        lane_r_q[k] <= '0;
        lane_i_q[k] <= '0;
      end
    end else if (accept) begin
      if (state_q == IDLE) begin
        for (int k = 0; k < MAX_N; k++) begin
          lane_r_q[k] <= '0;
          lane_i_q[k] <= '0;
        end
      end
      lane_r_q[lane_idx] <= sample_R_i;
      lane_i_q[lane_idx] <= sample_I_i;
    end
  end

  for (genvar k = 0; k < MAX_N; k++) begin : g_lanes
    assign X_R_o[k*DATA_W +: DATA_W] = lane_r_q[k];
    assign X_I_o[k*DATA_W +: DATA_W] = lane_i_q[k];
  end

endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 Parameter DATA_W, default 16: width of each real or imaginary sample.
REQ-002 Parameter MAX_N, default 32: number of output lanes.
REQ-003 clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 rst_i  in  1  reset; synchronous, active-high.
REQ-005 fft_select_i  in  2  transform size: 0=8, 1=16, 2=32, 3=reserved.
REQ-006 sample_valid_i  in  1  serial sample offered.
REQ-007 sample_ready_o  out  1  loader accepts a sample this cycle.
REQ-008 sample_R_i / sample_I_i  in  DATA_W each  real / imaginary part of the serial sample.
REQ-009 X_R_o / X_I_o  out  MAX_N*DATA_W each  parallel lanes; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-010 start_fft8_o / start_fft16_o / start_fft32_o  out  1 each  one-cycle start strobe to the selected engine.
REQ-011 fft_done_i  in  1  the engine that was started has finished and released its inputs.
REQ-012 busy_o  out  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have four states: IDLE, LOAD, FIRE and WAIT.
REQ-014 sample_ready_o SHALL be high in IDLE when fft_select_i != 3, high in LOAD, and low otherwise.
REQ-015 A sample is accepted on a cycle where sample_valid_i and sample_ready_o are both high.
REQ-016 In IDLE with select=3, the loader SHALL accept nothing and SHALL not change state.
REQ-017 The first accepted sample in IDLE SHALL latch N from fft_select_i, zero all MAX_N lanes, and write itself to lane 0 in the same cycle.
REQ-018 fft_select_i changes after the latch SHALL be ignored until the next IDLE.
REQ-019 A counter cnt (log2 MAX_N bits) SHALL count accepted samples in the frame.
REQ-020 Accepted sample number cnt SHALL be written to lane bitrev(cnt, log2 N): cnt is bit-reversed over log2 N bits.
REQ-021 Lanes at or above N SHALL stay zero for the whole frame.
REQ-022 IDLE SHALL go to LOAD after the first acceptance when N > 1; it SHALL go straight to FIRE only if that acceptance completes the frame.
REQ-023 LOAD SHALL go to FIRE on the cycle the N-th sample is accepted (cnt = N-1).
REQ-024 Cycles where sample_valid_i is low SHALL stall LOAD without losing any data.
REQ-025 FIRE SHALL last one cycle and assert exactly the start strobe matching the latched N; the other two strobes stay low.
REQ-026 FIRE SHALL always go to WAIT.
REQ-027 Latency: last sample accepted in cycle t; strobe high in cycle t+1; all N lanes valid in cycle t+1.
REQ-028 X_R_o and X_I_o SHALL hold stable from FIRE until the WAIT-to-IDLE transition.
REQ-029 WAIT SHALL go to IDLE on the cycle after fft_done_i is sampled high.
REQ-030 fft_done_i SHALL be ignored outside WAIT.
REQ-031 Lane contents SHALL be retained in IDLE until the next frame's first acceptance.
REQ-032 Sample data is stored unmodified: no arithmetic, no sign extension.

Reset
REQ-033 While rst_i is high at a clock edge: state becomes IDLE, cnt=0, latched N=8, all lanes 0, all strobes 0.
REQ-034 Reset outputs: sample_ready_o follows REQ-014, busy_o=0.
REQ-035 Reset in any state, including mid-LOAD or during FIRE, SHALL abort the frame; no start strobe is issued on or after the reset cycle.

Structure
REQ-036 Shared package fft_pkg SHALL hold: DATA_W, MAX_N, select encodings (FFT_SEL_8/16/32/RSVD), state enumeration, and the select-to-log2N mapping.
REQ-037 Bit reversal SHALL live in sub-module fft_bitrev_addr (inputs cnt and log2N, output lane index), purely combinational.

Verification
REQ-038 N=8, samples R=1..8 with I=0, valid held high: lanes 0..7 R = 1,5,3,7,2,6,4,8; lanes 8..31 = 0; start_fft8_o high exactly one cycle, the cycle after the 8th acceptance.
REQ-039 N=32, with valid toggled every other cycle: all 32 lanes in bit-reversed order; start_fft32_o fires once; sample_ready_o low from FIRE until the cycle after fft_done_i.
REQ-040 N=16, with fft_select_i changed to 2 after sample 3: frame still completes at 16 samples; start_fft16_o fires; lanes 16..31 = 0.
REQ-041 Select=3 with valid held high for 10 cycles: no acceptance, busy_o=0, no strobes.
REQ-042 rst_i pulsed after 5 of 8 samples: all lanes = 0, state IDLE, no strobe; a following full 8-sample frame loads correctly.
REQ-043 fft_done_i asserted during LOAD and during FIRE: ignored; an 8-sample frame followed by a 16-sample frame shows stale lanes 8..15 zeroed at the second frame's first acceptance.
